snake_pixel_pipe: RTL and testbench

Pixel-generation stage that sits directly downstream of the VGA timing generator. It maps each beam position onto a 40x30 grid of 16x16-pixel playfield cells and fetches the cell's contents from the synchronous playfield RAM. It then colours the pixel (wall, snake body, snake head, blinking food) and re-times hsync/vsync so that colour and sync leave the block aligned. It also counts frames for animation.

---
 rtl/snake_pixel_pipe_if.sv | 21 ++
 rtl/snake_pixel_pipe.sv | 155 +++++++++++++++
 tb/tb_snake_pixel_pipe.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/snake_pixel_pipe_if.sv
// Playfield RAM read port between the pixel pipe and the cell RAM.
// The pipe issues address/enable; the RAM answers one cycle later.
interface snake_pixel_pipe_if #(
    parameter int ADDR_W = 11
);
    logic              cell_rd;
    logic [ADDR_W-1:0] cell_addr;
    logic [1:0]        cell_data;

    modport master (
        output cell_rd,
        output cell_addr,
        input  cell_data
    );

    modport slave (
        input  cell_rd,
        input  cell_addr,
        output cell_data
    );
endinterface

// File: rtl/snake_pixel_pipe.sv
// Snake playfield pixel stage: beam -> cell fetch -> colour, with
// sync re-timed to the 3-cycle colour path and a frame/blink counter.
module snake_pixel_pipe #(
    parameter int CELL_SHIFT   = 4,
    parameter int GRID_W       = 40,
    parameter int GRID_H       = 30,
    parameter int ADDR_W       = 11,
    parameter int BLINK_FRAMES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       display_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    snake_pixel_pipe_if.master ram,
    output logic [1:0] vga_r,
    output logic [1:0] vga_g,
    output logic [1:0] vga_b,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [7:0] frame_count
);

    typedef enum logic [1:0] {
        CLS_BLANK = 2'd0,
        CLS_WALL  = 2'd1,
        CLS_CELL  = 2'd2
    } cls_t;

    typedef struct packed {
        cls_t cls;
        logic hs;
        logic vs;
    } stage_t;

    localparam logic [9:0] GW    = 10'(GRID_W);
    localparam logic [9:0] GH    = 10'(GRID_H);
    localparam logic [7:0] BMASK = 8'(BLINK_FRAMES - 1);

    logic [9:0]        col;
    logic [9:0]        row;
    logic              in_grid;
    logic              is_wall;
    logic [ADDR_W-1:0] row_a;
    logic [ADDR_W-1:0] col_a;
    logic [ADDR_W-1:0] addr;

    assign col     = pos_x >> CELL_SHIFT;
    assign row     = pos_y >> CELL_SHIFT;
    assign in_grid = display_on && (col < GW) && (row < GH);
    assign is_wall = (col == 10'd0) || (col == GW - 10'd1) ||
                     (row == 10'd0) || (row == GH - 10'd1);
    assign row_a   = ADDR_W'(row);
    assign col_a   = ADDR_W'(col);

    // 40 = 32 + 8, so the row stride is two shifts and an add
    generate
        if (GRID_W == 40) begin : g_addr_40
            assign addr = (row_a << 5) + (row_a << 3) + col_a;
        end else begin : g_addr_gen
            assign addr = row_a * ADDR_W'(GRID_W) + col_a;
        end
    endgenerate

    stage_t s1_d;
    stage_t s1;
    stage_t s2;

    always_comb begin
        s1_d.hs  = hsync_in;
        s1_d.vs  = vsync_in;
        s1_d.cls = CLS_BLANK;
        if (in_grid)
            s1_d.cls = is_wall ? CLS_WALL : CLS_CELL;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram.cell_rd   <= 1'b0;
            ram.cell_addr <= '0;
            s1            <= '{cls: CLS_BLANK, hs: 1'b0, vs: 1'b0};
            s2            <= '{cls: CLS_BLANK, hs: 1'b0, vs: 1'b0};
        end else begin
            ram.cell_rd <= in_grid;
            if (in_grid)
                ram.cell_addr <= addr;
            s1 <= s1_d;
            s2 <= s1;
        end
    end

    logic       blink_phase;
    logic       vs_d;
    logic       vs_armed;
    logic [7:0] fc_nxt;
    logic       vs_rise;

    assign fc_nxt  = frame_count + 8'd1;
    assign vs_rise = vs_armed && vsync_in && !vs_d;

    // The first cycle after release only primes the edge detector
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= 8'd0;
            blink_phase <= 1'b1;
            vs_d        <= 1'b0;
            vs_armed    <= 1'b0;
        end else begin
            vs_d     <= vsync_in;
            vs_armed <= 1'b1;
            if (vs_rise) begin
                frame_count <= fc_nxt;
                if ((fc_nxt & BMASK) == 8'd0)
                    blink_phase <= ~blink_phase;
            end
        end
    end

    logic [5:0] rgb;

    always_comb begin
        rgb = 6'b00_00_00;
        unique case (s2.cls)
            CLS_WALL: rgb = 6'b01_01_01;
            CLS_CELL: begin
                unique case (ram.cell_data)
                    2'b01:   rgb = 6'b00_10_00;
                    2'b10:   rgb = 6'b01_11_01;
                    2'b11:   rgb = blink_phase ? 6'b11_00_00 : 6'b00_00_00;
                    default: rgb = 6'b00_00_00;
                endcase
            end
            default: rgb = 6'b00_00_00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_r     <= 2'd0;
            vga_g     <= 2'd0;
            vga_b     <= 2'd0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            vga_r     <= rgb[5:4];
            vga_g     <= rgb[3:2];
            vga_b     <= rgb[1:0];
            hsync_out <= s2.hs;
            vsync_out <= s2.vs;
        end
    end

endmodule

// File: tb/tb_snake_pixel_pipe.sv
// Directed bench for snake_pixel_pipe with a synchronous playfield RAM
// model, vector table plus sync, blink/wrap and async reset sequences.
module tb_snake_pixel_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       display_on;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [1:0] vga_r;
    logic [1:0] vga_g;
    logic [1:0] vga_b;
    logic       hsync_out;
    logic       vsync_out;
    logic [7:0] frame_count;

    int n_chk = 0;
    int n_err = 0;

    logic [1:0] mem [0:2047];

    always #5 clk = ~clk;

    snake_pixel_pipe_if #(.ADDR_W(11)) ram_if ();

    snake_pixel_pipe dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .display_on  (display_on),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .ram         (ram_if.master),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .frame_count (frame_count)
    );

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ram_if.cell_data <= 2'b00;
        else if (ram_if.cell_rd)
            ram_if.cell_data <= mem[ram_if.cell_addr];
    end

    typedef struct {
        logic de;
        int   px;
        int   py;
        logic rd;
        int   addr;
        int   r;
        int   g;
        int   b;
    } vec_t;

    vec_t vt [9];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic vpulse;
        vsync_in = 1'b1;
        step();
        vsync_in = 1'b0;
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rise;
        int width;

        for (int i = 0; i < 2048; i++) mem[i] = 2'b00;
        mem[122] = 2'b01;
        mem[123] = 2'b10;
        mem[410] = 2'b11;
        mem[480] = 2'b11;
        mem[1199] = 2'b10;

        vt[0] = '{1'b1,  37,  50, 1'b1,  122, 0, 2, 0};
        vt[1] = '{1'b1, 639, 479, 1'b1, 1199, 1, 1, 1};
        vt[2] = '{1'b1,   5, 200, 1'b1,  480, 1, 1, 1};
        vt[3] = '{1'b1,  48,  48, 1'b1,  123, 1, 3, 1};
        vt[4] = '{1'b0, 700, 100, 1'b0,  123, 0, 0, 0};
        vt[5] = '{1'b1, 160, 160, 1'b1,  410, 3, 0, 0};
        vt[6] = '{1'b1,  20,  20, 1'b1,   41, 0, 0, 0};
        vt[7] = '{1'b1, 640, 100, 1'b0,   41, 0, 0, 0};
        vt[8] = '{1'b1, 100, 480, 1'b0,   41, 0, 0, 0};

        reset_n    = 1'b0;
        display_on = 1'b0;
        hsync_in   = 1'b0;
        vsync_in   = 1'b0;
        pos_x      = 10'd0;
        pos_y      = 10'd0;
        step();
        step();
        chk("reset_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("reset_rd", ram_if.cell_rd, 0);
        chk("reset_fc", frame_count, 0);
        chk("reset_hs", hsync_out, 0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            display_on = vt[i].de;
            pos_x      = 10'(vt[i].px);
            pos_y      = 10'(vt[i].py);
            step();
            chk($sformatf("v%0d_rd", i), ram_if.cell_rd, vt[i].rd);
            chk($sformatf("v%0d_addr", i), ram_if.cell_addr, vt[i].addr);
            step();
            step();
            chk($sformatf("v%0d_r", i), vga_r, vt[i].r);
            chk($sformatf("v%0d_g", i), vga_g, vt[i].g);
            chk($sformatf("v%0d_b", i), vga_b, vt[i].b);
        end

        display_on = 1'b0;
        pos_x      = 10'd700;
        rise       = -1;
        width      = 0;
        for (int i = 0; i < 120; i++) begin
            hsync_in = (i < 96);
            step();
            if (hsync_out && rise < 0) rise = i;
            if (hsync_out) width++;
        end
        chk("hs_delay", rise, 2);
        chk("hs_width", width, 96);

        display_on = 1'b1;
        pos_x      = 10'd160;
        pos_y      = 10'd160;
        step();
        step();
        step();
        chk("food_red_init", vga_r, 3);
        for (int k = 1; k <= 256; k++) begin
            vpulse();
            if (k == 16) begin
                chk("fc_16", frame_count, 16);
                chk("food_off_16", vga_r, 0);
            end
            if (k == 32) begin
                chk("fc_32", frame_count, 32);
                chk("food_on_32", vga_r, 3);
            end
            if (k == 256) begin
                chk("fc_wrap", frame_count, 0);
                chk("food_on_256", vga_r, 3);
            end
        end
        vpulse();
        vpulse();
        vpulse();
        chk("fc_3", frame_count, 3);

        pos_x    = 10'd37;
        pos_y    = 10'd50;
        hsync_in = 1'b1;
        step();
        step();
        step();
        chk("pre_rst_g", vga_g, 2);
        chk("pre_rst_hs", hsync_out, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_g", vga_g, 0);
        chk("async_hs", hsync_out, 0);
        chk("async_rd", ram_if.cell_rd, 0);
        chk("async_addr", ram_if.cell_addr, 0);
        chk("async_fc", frame_count, 0);
        step();
        reset_n = 1'b1;
        chk("rel0_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("rel0_hs", hsync_out, 0);
        step();
        chk("rel1_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("rel1_hs", hsync_out, 0);
        step();
        chk("rel2_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("rel2_hs", hsync_out, 0);
        step();
        chk("rel3_g", vga_g, 2);
        chk("rel3_hs", hsync_out, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
